// File: rtl/calc_display_pkg.sv
// Shared display constants for the calculator: 7-segment code points, digit count,
// signed display limits and the result formatter's FSM encoding.
package calc_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_E     = 4'hE;

  // A negative value spends one display position on the minus sign.
  localparam int unsigned POS_MAX = 999999;
  localparam int unsigned NEG_MAX = 99999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FORMAT = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/result_bcd_formatter.sv
// Converts a captured arithmetic result to six 7-segment display codes using a
// sequential double-dabble engine with fixed latency; one conversion in flight.
//
// Handshake: i_start is sampled only while o_busy=0; o_busy covers LOAD..FORMAT,
// and o_valid pulses for exactly one cycle after the FORMAT edge, when o_busy is already low.
module result_bcd_formatter
  import calc_display_pkg::*;
#(
  parameter int WIDTH_IN = 40,
  parameter int BIN_BITS = 20
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic [WIDTH_IN-1:0]       i_result,
  input  logic                      i_sign,
  input  logic                      i_err,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic [4*NUM_DIGITS-1:0]   o_digits,
  output state_t                    o_dbg_state
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_BITS;
  localparam int CNT_W = $clog2(BIN_BITS);
  localparam int MSD_W = $clog2(NUM_DIGITS);

  localparam logic [WIDTH_IN-1:0] W_POS_MAX = WIDTH_IN'(POS_MAX);
  localparam logic [WIDTH_IN-1:0] W_NEG_MAX = WIDTH_IN'(NEG_MAX);

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH_IN-1:0] r_result;
  logic                r_sign;
  logic                r_err;
  logic                r_ovf;
  logic [SR_W-1:0]     r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BCD_W-1:0]    r_digits;
  logic                r_valid;

  logic [BCD_W-1:0]    w_bcd;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W-1:0]    w_fmt;
  logic [MSD_W-1:0]    w_msd;
  logic                w_nonzero;

  assign w_bcd = r_sr[SR_W-1:BIN_BITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nibble (w_bcd[g*4 +: 4]),
      .o_nibble (w_bcd_adj[g*4 +: 4])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_next_state = ST_LOAD;
      ST_LOAD:   w_next_state = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == '0) w_next_state = ST_FORMAT;
      ST_FORMAT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Datapath; the shift phase runs even on overflow so latency never varies.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_result <= '0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_digits <= {NUM_DIGITS{CODE_BLANK}};
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_result <= i_result;
            r_sign   <= i_sign;
            r_err    <= i_err;
          end
        end
        ST_LOAD: begin
          r_ovf <= r_err | (r_sign ? (r_result > W_NEG_MAX) : (r_result > W_POS_MAX));
          r_sr  <= {{BCD_W{1'b0}}, r_result[BIN_BITS-1:0]};
          r_cnt <= CNT_W'(BIN_BITS - 1);
        end
        ST_SHIFT: begin
          r_sr  <= {w_bcd_adj[BCD_W-2:0], r_sr[BIN_BITS-1:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
        end
        ST_FORMAT: begin
          r_digits <= w_fmt;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Blank leading zeros, keep the units digit, place the minus just left of the top digit.
  always_comb begin
    w_msd     = '0;
    w_nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_bcd[i*4 +: 4] != 4'd0) begin
        w_msd     = MSD_W'(i);
        w_nonzero = 1'b1;
      end
    end
    w_fmt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i > int'(w_msd)) begin
        w_fmt[i*4 +: 4] = CODE_BLANK;
      end else begin
        w_fmt[i*4 +: 4] = w_bcd[i*4 +: 4];
      end
      if (r_sign && w_nonzero && (i == int'(w_msd) + 1)) begin
        w_fmt[i*4 +: 4] = CODE_MINUS;
      end
    end
    if (r_ovf) begin
      w_fmt = {NUM_DIGITS{CODE_BLANK}};
      w_fmt[BCD_W-1 -: 4] = CODE_E;
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_valid     = r_valid;
  assign o_digits    = r_digits;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed bench for result_bcd_formatter: latency, formatting, overflow, handshake and reset abort.
module tb_result_bcd_formatter;
  import calc_display_pkg::*;

  localparam int LAT = 22;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic [39:0] i_result;
  logic        i_sign;
  logic        i_err;
  logic        o_busy;
  logic        o_valid;
  logic [23:0] o_digits;
  state_t      o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  result_bcd_formatter dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .i_result    (i_result),
    .i_sign      (i_sign),
    .i_err       (i_err),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_digits    (o_digits),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  // Pulses i_start for one edge, then scrambles the inputs to show they are no longer sampled.
  task automatic start_conv(input logic [39:0] v, input logic s, input logic e);
    @(negedge clk);
    i_result = v;
    i_sign   = s;
    i_err    = e;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    i_result = 40'hDE_ADBE_EFAA;
    i_sign   = ~s;
    i_err    = 1'b0;
  endtask

  // Returns the number of edges after the start edge at which o_valid was seen.
  task automatic wait_valid(output int cyc, output bit busy_ok, output bit timed_out);
    cyc       = 0;
    busy_ok   = 1'b1;
    timed_out = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (o_valid) begin
        cyc       = n;
        timed_out = 1'b0;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_result  = '0;
    i_sign    = 1'b0;
    i_err     = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b valid=%b required 0 0", o_busy, o_valid);
    end
    n_checks++;
    if (o_digits !== 24'hBBBBBB) begin
      n_fail++;
      $display("FAIL reset_digits: got %h required bbbbbb", o_digits);
    end
    n_checks++;
    if (o_dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", o_dbg_state, ST_IDLE);
    end
    i_reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; bit bok; bit to;
    start_conv(40'd123456, 1'b0, 1'b0);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_start: busy=%b required 1", o_busy);
    end
    wait_valid(cyc, bok, to);
    n_checks++;
    if (to || cyc != LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d (timeout=%0d) required %0d", cyc, to, LAT);
    end
    n_checks++;
    if (o_digits !== 24'h123456) begin
      n_fail++;
      $display("FAIL basic_digits: got %h required 123456", o_digits);
    end
    n_checks++;
    if (!bok || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy_during=%0d busy_at_valid=%b required 1 0", bok, o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_digits !== 24'h123456) begin
      n_fail++;
      $display("FAIL basic_pulse: valid=%b digits=%h required 0 123456", o_valid, o_digits);
    end
  endtask

  task automatic test_negative();
    logic [39:0] vals[2];
    logic [23:0] exps[2];
    int cyc; bit bok; bit to;
    vals[0] = 40'd42; exps[0] = 24'hBBBA42;
    vals[1] = 40'd0;  exps[1] = 24'hBBBBB0;
    for (int i = 0; i < 2; i++) begin
      start_conv(vals[i], 1'b1, 1'b0);
      wait_valid(cyc, bok, to);
      n_checks++;
      if (to || o_digits !== exps[i]) begin
        n_fail++;
        $display("FAIL negative_%0d: got %h (timeout=%0d) required %h", i, o_digits, to, exps[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [39:0] vals[6];
    logic        sgn[6];
    logic        err[6];
    logic [23:0] exps[6];
    int cyc; bit bok; bit to;
    vals[0] = 40'd1000000;     sgn[0] = 0; err[0] = 0; exps[0] = 24'hEBBBBB;
    vals[1] = 40'd100000;      sgn[1] = 1; err[1] = 0; exps[1] = 24'hEBBBBB;
    vals[2] = 40'd99999;       sgn[2] = 1; err[2] = 0; exps[2] = 24'hA99999;
    vals[3] = 40'd5;           sgn[3] = 0; err[3] = 1; exps[3] = 24'hEBBBBB;
    vals[4] = 40'h10_0000_0007; sgn[4] = 0; err[4] = 0; exps[4] = 24'hEBBBBB;
    vals[5] = 40'd999999;      sgn[5] = 0; err[5] = 0; exps[5] = 24'h999999;
    for (int i = 0; i < 6; i++) begin
      start_conv(vals[i], sgn[i], err[i]);
      wait_valid(cyc, bok, to);
      n_checks++;
      if (to || cyc != LAT || o_digits !== exps[i]) begin
        n_fail++;
        $display("FAIL overflow_%0d: got %h lat=%0d (timeout=%0d) required %h lat=%0d",
                 i, o_digits, cyc, to, exps[i], LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n_valid = 0;
    logic [23:0] seen = '0;
    start_conv(40'd314159, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    i_result = 40'd1;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (o_valid) begin
        n_valid++;
        seen = o_digits;
      end
    end
    n_checks++;
    if (n_valid != 1 || seen !== 24'h314159) begin
      n_fail++;
      $display("FAIL ignore_start: valids=%0d digits=%h required 1 314159", n_valid, seen);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok; bit to;
    start_conv(40'd111111, 1'b0, 1'b0);
    wait_valid(cyc, bok, to);
    n_checks++;
    if (to || o_digits !== 24'h111111) begin
      n_fail++;
      $display("FAIL b2b_first: got %h (timeout=%0d) required 111111", o_digits, to);
    end
    i_result = 40'd222222;
    i_sign   = 1'b0;
    i_err    = 1'b0;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b required 1", o_busy);
    end
    wait_valid(cyc, bok, to);
    n_checks++;
    if (to || cyc != LAT || o_digits !== 24'h222222) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat=%0d (timeout=%0d) required 222222 lat=%0d",
               o_digits, cyc, to, LAT);
    end
  endtask

  task automatic test_mid_reset();
    int n_valid = 0;
    int cyc; bit bok; bit to;
    start_conv(40'd777777, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (o_dbg_state !== ST_SHIFT) begin
      n_fail++;
      $display("FAIL rst_in_shift: state=%0d required %0d", o_dbg_state, ST_SHIFT);
    end
    i_reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_digits !== 24'hBBBBBB) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b valid=%b digits=%h required 0 0 bbbbbb",
               o_busy, o_valid, o_digits);
    end
    i_reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_valid) n_valid++;
    end
    n_checks++;
    if (n_valid != 0) begin
      n_fail++;
      $display("FAIL rst_no_valid: valids=%0d required 0", n_valid);
    end
    start_conv(40'd999999, 1'b0, 1'b0);
    wait_valid(cyc, bok, to);
    n_checks++;
    if (to || cyc != LAT || o_digits !== 24'h999999) begin
      n_fail++;
      $display("FAIL rst_restart: got %h lat=%0d (timeout=%0d) required 999999 lat=%0d",
               o_digits, cyc, to, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
